// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if
// Groups the fetch/decode signals exchanged between the MIPS pipeline and the
// branch predictor.
//   master : pipeline side. It drives pcF, stallD, flushD, branchD, pcD, takenD
//            and targetD, and receives the prediction, redirect and statistics.
//   slave  : predictor side (branch_predict_unit).
// CNT_W sets the width of the brCount/mispCount statistics counters.
interface branch_predict_unit_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pcF;
  logic             stallD;
  logic             flushD;
  logic             branchD;
  logic [31:0]      pcD;
  logic             takenD;
  logic [31:0]      targetD;
  logic             brbitF;
  logic [31:0]      predTargetF;
  logic [1:0]       brmuxsel;
  logic             mispredictD;
  logic             branchCorrect;
  logic [CNT_W-1:0] brCount;
  logic [CNT_W-1:0] mispCount;

  modport master (
    output pcF, stallD, flushD, branchD, pcD, takenD, targetD,
    input  brbitF, predTargetF, brmuxsel, mispredictD, branchCorrect,
           brCount, mispCount
  );

  modport slave (
    input  pcF, stallD, flushD, branchD, pcD, takenD, targetD,
    output brbitF, predTargetF, brmuxsel, mispredictD, branchCorrect,
           brCount, mispCount
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Dynamic branch predictor and redirect controller for the 5-stage MIPS core.
// A direct-mapped BTB with 2-bit saturating counters is looked up
// combinationally with pcF. The prediction travels to decode in predD and is
// compared there with the resolved outcome.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bp    : branch_predict_unit_if.slave
//           inputs  pcF, stallD, flushD, branchD, pcD, takenD, targetD
//           outputs brbitF, predTargetF, brmuxsel, mispredictD,
//                   branchCorrect, brCount, mispCount
module branch_predict_unit #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  branch_predict_unit_if.slave bp
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int USED_MSB = IDX_BITS + TAG_BITS;

  logic [ENTRIES-1:0]  validQ;
  logic [TAG_BITS-1:0] tagQ    [ENTRIES];
  logic [31:0]         targetQ [ENTRIES];
  logic [1:0]          ctrQ    [ENTRIES];

  logic             predD;
  logic [CNT_W-1:0] brCountQ;
  logic [CNT_W-1:0] mispCountQ;

  logic [IDX_BITS-1:0] idxF;
  logic [IDX_BITS-1:0] idxD;
  logic [TAG_BITS-1:0] tagF;
  logic [TAG_BITS-1:0] tagD;
  logic                hitF;
  logic                hitD;
  logic                brbitF;
  logic                resolveD;
  logic                mispD;
  logic [1:0]          brmuxselC;

  // PC bits above the tag do not take part in the lookup.
  logic unusedPcBits;
  assign unusedPcBits = ^{bp.pcF[31:USED_MSB], bp.pcD[31:USED_MSB]};

  assign idxF = bp.pcF[IDX_BITS-1:0];
  assign tagF = bp.pcF[USED_MSB-1:IDX_BITS];
  assign idxD = bp.pcD[IDX_BITS-1:0];
  assign tagD = bp.pcD[USED_MSB-1:IDX_BITS];

  // Fetch reads the registered BTB, so a same-cycle decode update is only
  // visible from the following cycle.
  assign hitF   = validQ[idxF] && (tagQ[idxF] == tagF);
  assign brbitF = hitF & ctrQ[idxF][1];
  assign hitD   = validQ[idxD] && (tagQ[idxD] == tagD);

  assign resolveD = bp.branchD & ~bp.stallD;
  assign mispD    = resolveD & (predD != bp.takenD);

  always_comb begin
    brmuxselC = 2'b00;
    if (mispD) begin
      brmuxselC = bp.takenD ? 2'b10 : 2'b11;
    end else if (brbitF) begin
      brmuxselC = 2'b01;
    end
  end

  assign bp.brbitF        = brbitF;
  assign bp.predTargetF   = brbitF ? targetQ[idxF] : 32'h0;
  assign bp.brmuxsel      = brmuxselC;
  assign bp.mispredictD   = mispD;
  assign bp.branchCorrect = ~mispD;
  assign bp.brCount       = brCountQ;
  assign bp.mispCount     = mispCountQ;

  // Prediction pipeline register and statistics. A misprediction flushes the
  // fetch/decode register, so the wrong-path prediction is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      predD      <= 1'b0;
      brCountQ   <= '0;
      mispCountQ <= '0;
    end else begin
      if (!bp.stallD) begin
        predD <= (mispD | bp.flushD) ? 1'b0 : brbitF;
      end
      if (resolveD && (brCountQ != '1)) begin
        brCountQ <= brCountQ + CNT_W'(1);
      end
      if (mispD && (mispCountQ != '1)) begin
        mispCountQ <= mispCountQ + CNT_W'(1);
      end
    end
  end

  // BTB update. Tag and target need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctrQ[i] <= 2'b01;
      end
    end else if (resolveD) begin
      if (hitD) begin
        if (bp.takenD) begin
          if (ctrQ[idxD] != 2'b11) begin
            ctrQ[idxD] <= ctrQ[idxD] + 2'b01;
          end
          targetQ[idxD] <= bp.targetD;
        end else if (ctrQ[idxD] != 2'b00) begin
          ctrQ[idxD] <= ctrQ[idxD] - 2'b01;
        end
      end else if (bp.takenD) begin
        validQ[idxD]  <= 1'b1;
        tagQ[idxD]    <= tagD;
        targetQ[idxD] <= bp.targetD;
        ctrQ[idxD]    <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
// Self-checking bench for branch_predict_unit. Directed scenarios follow the
// predictor's documented behaviour; a randomized phase compares every output
// against a behavioural model of the BTB, prediction register and statistics.
module tb_branch_predict_unit;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_predict_unit #(
    .IDX_BITS(4),
    .TAG_BITS(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bp(bus)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Behavioural model: 16-entry table of {valid, tag, target, counter 0..3}.
  bit          mValid [16];
  int          mTag   [16];
  logic [31:0] mTarget[16];
  int          mCtr   [16];
  bit          mPredD;
  int          mBr;
  int          mMisp;

  function automatic int idxOf(logic [31:0] pc);
    return int'(pc % 32'd16);
  endfunction

  function automatic int tagOf(logic [31:0] pc);
    return int'((pc / 32'd16) % 32'd256);
  endfunction

  function automatic bit expBrbit(logic [31:0] pc);
    int i = idxOf(pc);
    return mValid[i] && (mTag[i] == tagOf(pc)) && (mCtr[i] >= 2);
  endfunction

  function automatic logic [31:0] expTarget(logic [31:0] pc);
    return expBrbit(pc) ? mTarget[idxOf(pc)] : 32'h0;
  endfunction

  function automatic bit expMisp();
    return bus.branchD && !bus.stallD && (mPredD != bus.takenD);
  endfunction

  function automatic logic [1:0] expSel();
    if (expMisp()) return bus.takenD ? 2'd2 : 2'd3;
    if (expBrbit(bus.pcF)) return 2'd1;
    return 2'd0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    bit b = expBrbit(bus.pcF);
    bit m = expMisp();
    int i = idxOf(bus.pcD);
    bit hit;
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        mValid[k] = 1'b0;
        mCtr[k]   = 1;
      end
      mPredD = 1'b0;
      mBr    = 0;
      mMisp  = 0;
      return;
    end
    if (bus.branchD && !bus.stallD) begin
      if (mBr < CNT_MAX) mBr++;
      if (m && mMisp < CNT_MAX) mMisp++;
      hit = mValid[i] && (mTag[i] == tagOf(bus.pcD));
      if (hit) begin
        if (bus.takenD) begin
          mCtr[i]    = (mCtr[i] == 3) ? 3 : mCtr[i] + 1;
          mTarget[i] = bus.targetD;
        end else begin
          mCtr[i] = (mCtr[i] == 0) ? 0 : mCtr[i] - 1;
        end
      end else if (bus.takenD) begin
        mValid[i]  = 1'b1;
        mTag[i]    = tagOf(bus.pcD);
        mTarget[i] = bus.targetD;
        mCtr[i]    = 2;
      end
    end
    if (!bus.stallD) mPredD = (m || bus.flushD) ? 1'b0 : b;
  endtask

  task automatic drive(bit rst, logic [31:0] pcF, bit stall, bit flush, bit br,
                       logic [31:0] pcD, bit taken, logic [31:0] tgt);
    @(negedge clk);
    reset       = rst;
    bus.pcF     = pcF;
    bus.stallD  = stall;
    bus.flushD  = flush;
    bus.branchD = br;
    bus.pcD     = pcD;
    bus.takenD  = taken;
    bus.targetD = tgt;
    #1;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b0) begin nErrors++; $display("FAIL reset_brbitF got=%0b exp=0", bus.brbitF); end
    nChecks++; if (bus.predTargetF !== 32'h0) begin nErrors++; $display("FAIL reset_predTargetF got=%h exp=0", bus.predTargetF); end
    nChecks++; if (bus.brmuxsel !== 2'b00) begin nErrors++; $display("FAIL reset_brmuxsel got=%b exp=00", bus.brmuxsel); end
    nChecks++; if (bus.mispredictD !== 1'b0) begin nErrors++; $display("FAIL reset_mispredictD got=%0b exp=0", bus.mispredictD); end
    nChecks++; if (bus.branchCorrect !== 1'b1) begin nErrors++; $display("FAIL reset_branchCorrect got=%0b exp=1", bus.branchCorrect); end
    nChecks++; if (bus.brCount !== 4'd0 || bus.mispCount !== 4'd0) begin nErrors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.brCount, bus.mispCount); end
    tick();
  endtask

  task automatic test_cold_miss();
    drive(0, 0, 0, 0, 1, 32'h5, 1, 32'h10);
    nChecks++; if (bus.mispredictD !== 1'b1) begin nErrors++; $display("FAIL cold_misp got=%0b exp=1", bus.mispredictD); end
    nChecks++; if (bus.brmuxsel !== 2'b10) begin nErrors++; $display("FAIL cold_sel got=%b exp=10", bus.brmuxsel); end
    nChecks++; if (bus.branchCorrect !== 1'b0) begin nErrors++; $display("FAIL cold_branchCorrect got=%0b exp=0", bus.branchCorrect); end
    tick();
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b1) begin nErrors++; $display("FAIL cold_hit_brbit got=%0b exp=1", bus.brbitF); end
    nChecks++; if (bus.predTargetF !== 32'h10) begin nErrors++; $display("FAIL cold_hit_target got=%h exp=10", bus.predTargetF); end
    nChecks++; if (bus.brmuxsel !== 2'b01) begin nErrors++; $display("FAIL cold_hit_sel got=%b exp=01", bus.brmuxsel); end
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h5, 0, 0, 1, 32'h5, 1, 32'h10);
      nChecks++; if (bus.mispredictD !== expMisp()) begin nErrors++; $display("FAIL sat_taken_misp[%0d] got=%0b exp=%0b", k, bus.mispredictD, expMisp()); end
      tick();
    end
    drive(0, 32'h5, 0, 0, 1, 32'h5, 0, 0);
    nChecks++; if (bus.mispredictD !== 1'b1 || bus.brmuxsel !== 2'b11) begin nErrors++; $display("FAIL sat_nt1 got misp=%0b sel=%b exp 1/11", bus.mispredictD, bus.brmuxsel); end
    tick();
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b1) begin nErrors++; $display("FAIL sat_after_nt1_brbit got=%0b exp=1", bus.brbitF); end
    tick();
    drive(0, 32'h5, 0, 0, 1, 32'h5, 0, 0);
    nChecks++; if (bus.mispredictD !== 1'b1 || bus.brmuxsel !== 2'b11) begin nErrors++; $display("FAIL sat_nt2 got misp=%0b sel=%b exp 1/11", bus.mispredictD, bus.brmuxsel); end
    tick();
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b0 || bus.brmuxsel !== 2'b00) begin nErrors++; $display("FAIL sat_after_nt2 got brbit=%0b sel=%b exp 0/00", bus.brbitF, bus.brmuxsel); end
    tick();
  endtask

  task automatic test_aliasing();
    drive(0, 32'h15, 0, 0, 1, 32'h5, 1, 32'h10);
    nChecks++; if (bus.brbitF !== 1'b0) begin nErrors++; $display("FAIL alias_lookup_a got=%0b exp=0", bus.brbitF); end
    tick();
    drive(0, 32'h15, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b0) begin nErrors++; $display("FAIL alias_lookup_b got=%0b exp=0", bus.brbitF); end
    tick();
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b1) begin nErrors++; $display("FAIL alias_own_hit got=%0b exp=1", bus.brbitF); end
    tick();
    drive(0, 0, 0, 0, 1, 32'h15, 1, 32'h40);
    nChecks++; if (bus.mispredictD !== expMisp()) begin nErrors++; $display("FAIL alias_alloc_misp got=%0b exp=%0b", bus.mispredictD, expMisp()); end
    tick();
    drive(0, 32'h15, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b1 || bus.predTargetF !== 32'h40) begin nErrors++; $display("FAIL alias_new_hit got=%0b/%h exp=1/40", bus.brbitF, bus.predTargetF); end
    tick();
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b0) begin nErrors++; $display("FAIL alias_old_miss got=%0b exp=0", bus.brbitF); end
    tick();
  endtask

  task automatic test_stall();
    int savedBr;
    drive(0, 32'h15, 0, 0, 0, 0, 0, 0);
    tick();
    savedBr = mBr;
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h15, 1, 0, 1, 32'h15, 0, 0);
      nChecks++; if (bus.mispredictD !== 1'b0) begin nErrors++; $display("FAIL stall_misp[%0d] got=%0b exp=0", k, bus.mispredictD); end
      nChecks++; if (bus.brCount !== 4'(savedBr) || bus.brbitF !== 1'b1) begin nErrors++; $display("FAIL stall_hold[%0d] got cnt=%0d brbit=%0b exp %0d/1", k, bus.brCount, bus.brbitF, savedBr); end
      tick();
    end
    drive(0, 0, 0, 0, 1, 32'h15, 0, 0);
    nChecks++; if (bus.mispredictD !== 1'b1 || bus.brmuxsel !== 2'b11) begin nErrors++; $display("FAIL stall_release got misp=%0b sel=%b exp 1/11", bus.mispredictD, bus.brmuxsel); end
    tick();
    drive(0, 32'h15, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brCount !== 4'(savedBr + 1)) begin nErrors++; $display("FAIL stall_count got=%0d exp=%0d", bus.brCount, savedBr + 1); end
    nChecks++; if (bus.brbitF !== 1'b0) begin nErrors++; $display("FAIL stall_ctr_dec got=%0b exp=0", bus.brbitF); end
    tick();
  endtask

  task automatic test_same_cycle();
    drive(0, 32'h15, 0, 0, 1, 32'h15, 1, 32'h50);
    nChecks++; if (bus.brbitF !== 1'b0) begin nErrors++; $display("FAIL samecyc_pre got=%0b exp=0", bus.brbitF); end
    tick();
    drive(0, 32'h15, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brbitF !== 1'b1 || bus.predTargetF !== 32'h50) begin nErrors++; $display("FAIL samecyc_post got=%0b/%h exp=1/50", bus.brbitF, bus.predTargetF); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pf, pd;
    for (int c = 0; c < 400; c++) begin
      pf = 32'($urandom_range(0, 47)) | ($urandom & 32'hFFFF_F000);
      pd = ($urandom_range(0, 3) == 0) ? pf : (32'($urandom_range(0, 47)) | ($urandom & 32'hFFFF_F000));
      drive($urandom_range(0, 39) == 0, pf, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, pd,
            $urandom_range(0, 1) == 1, $urandom);
      nChecks++; if (bus.brbitF !== expBrbit(pf)) begin nErrors++; $display("FAIL rnd_brbit c=%0d got=%0b exp=%0b", c, bus.brbitF, expBrbit(pf)); end
      nChecks++; if (bus.predTargetF !== expTarget(pf)) begin nErrors++; $display("FAIL rnd_target c=%0d got=%h exp=%h", c, bus.predTargetF, expTarget(pf)); end
      nChecks++; if (bus.brmuxsel !== expSel()) begin nErrors++; $display("FAIL rnd_sel c=%0d got=%b exp=%b", c, bus.brmuxsel, expSel()); end
      nChecks++; if (bus.mispredictD !== expMisp() || bus.branchCorrect !== !expMisp()) begin nErrors++; $display("FAIL rnd_misp c=%0d got=%0b/%0b exp=%0b", c, bus.mispredictD, bus.branchCorrect, expMisp()); end
      nChecks++; if (bus.brCount !== 4'(mBr) || bus.mispCount !== 4'(mMisp)) begin nErrors++; $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.brCount, bus.mispCount, mBr, mMisp); end
      tick();
    end
  endtask

  task automatic test_stats_saturation();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 32'h3FF, 0, 0, 1, 32'(i), 1, 32'h100 + 32'(i));
      nChecks++; if (bus.mispredictD !== 1'b1) begin nErrors++; $display("FAIL statsat_misp[%0d] got=%0b exp=1", i, bus.mispredictD); end
      tick();
    end
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brCount !== 4'd15 || bus.mispCount !== 4'd15) begin nErrors++; $display("FAIL statsat_counts got=%0d/%0d exp=15/15", bus.brCount, bus.mispCount); end
    nChecks++; if (bus.brbitF !== 1'b1) begin nErrors++; $display("FAIL statsat_entry got=%0b exp=1", bus.brbitF); end
    tick();
    drive(1, 32'h3FF, 0, 0, 1, 32'h7, 1, 32'h10);
    tick();
    drive(0, 32'h5, 0, 0, 0, 0, 0, 0);
    nChecks++; if (bus.brCount !== 4'd0 || bus.mispCount !== 4'd0) begin nErrors++; $display("FAIL midreset_counts got=%0d/%0d exp=0/0", bus.brCount, bus.mispCount); end
    nChecks++; if (bus.brbitF !== 1'b0 || bus.brmuxsel !== 2'b00 || bus.branchCorrect !== 1'b1) begin nErrors++; $display("FAIL midreset_outputs got brbit=%0b sel=%b bc=%0b exp 0/00/1", bus.brbitF, bus.brmuxsel, bus.branchCorrect); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.pcF = 0; bus.stallD = 0; bus.flushD = 0; bus.branchD = 0;
    bus.pcD = 0; bus.takenD = 0; bus.targetD = 0;
    test_reset();
    test_cold_miss();
    test_saturation();
    test_aliasing();
    test_stall();
    test_same_cycle();
    test_random();
    test_stats_saturation();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
